sub3: RTL

Pipelined three-operand unsigned subtractor computing q = a − b − c. It is the inverse-direction companion of the three-operand adder in the same datapath. It is used wherever an accumulated sum must be backed out, for example removing two partial terms from a running total. It mirrors the adder's two-stage, latency-parameterised pipeline and adds four things:

- a valid tag,
- a pipeline stall (clock enable),
- a synchronous reset,
- a sign/borrow flag.

---
 rtl/sub3.sv | 54 +++++
 1 files changed

// File: rtl/sub3.sv
// sub3: pipelined three-operand unsigned subtractor q = a - b - c with valid, stall and sign flag.
module sub3 #(
  parameter int latency = 3,
  parameter int a_bits  = 32,
  parameter int b_bits  = 32,
  parameter int c_bits  = 32,
  parameter int q_bits  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_valid,
  input  logic [a_bits-1:0] i_a,
  input  logic [b_bits-1:0] i_b,
  input  logic [c_bits-1:0] i_c,
  output logic              o_valid,
  output logic [q_bits-1:0] o_q,
  output logic              o_neg
);
  localparam int W = q_bits + 2;
  logic [W-1:0]       d [latency];
  logic [c_bits-1:0]  c [latency];
  logic [W-1:0]       r [latency];
  logic [latency-1:0] v1, v2;
  logic               unused_bit;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < latency; i++) begin
        d[i] <= '0;
        c[i] <= '0;
        r[i] <= '0;
      end
      v1 <= '0;
      v2 <= '0;
    end else if (i_ce) begin
      d[0]  <= W'(i_a) - W'(i_b);
      c[0]  <= i_c;
      v1[0] <= i_valid;
      r[0]  <= d[latency-1] - W'(c[latency-1]);
      v2[0] <= v1[latency-1];
      for (int i = 1; i < latency; i++) begin
        d[i]  <= d[i-1];
        c[i]  <= c[i-1];
        v1[i] <= v1[i-1];
        r[i]  <= r[i-1];
        v2[i] <= v2[i-1];
      end
    end
  end
  assign o_q        = r[latency-1][q_bits-1:0];
  assign o_neg      = r[latency-1][W-1];
  assign o_valid    = v2[latency-1];
  assign unused_bit = r[latency-1][q_bits];
endmodule
